// File: rtl/axi_ram_bridge_if.sv
// AXI4-Lite bus bundle between a master and the RAM bridge slave.
// No parameters; every AXI4-Lite signal is a fixed width.
interface axi_ram_bridge_if;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport slave (
        input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awprot,
        input  axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport master (
        output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        output axi_awaddr, axi_awvalid, axi_awprot,
        output axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/axi_ram_bridge.sv
// AXI4-Lite slave onto a single-port BRAM, one transaction at a time.
// Optional macro AXI_RAM_BRIDGE_ALIGN_CHECK_EN: reject misaligned accesses with SLVERR.
module axi_ram_bridge #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_ram_bridge_if.slave      axi,
    output logic [ADDR_BITS-3:0] ram_addr,
    output logic                 ram_en,
    output logic [3:0]           ram_we,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_RESP  = 3'd3,
        WR_ISSUE = 3'd4,
        WR_RESP  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        aw_lat_q, aw_lat_d;
    logic        w_lat_q, w_lat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        arready_c, awready_c, wready_c, ar_hs;
    logic        ram_en_c;
    logic [3:0]  ram_we_c;
    logic [ADDR_BITS-3:0] ram_addr_c;
    logic [31:0] ram_wdata_c;
    logic [1:0]  resp_c;
    logic        acc_ok;
    logic        unused_ok;

    // Reads and writes share addr_q: a read is only accepted with no AW/W latched.
    always_comb begin
        resp_c = 2'b00;
        if (|addr_q[31:ADDR_BITS]) begin
            resp_c = 2'b11;
        end
`ifdef AXI_RAM_BRIDGE_ALIGN_CHECK_EN
        else if (addr_q[1:0] != 2'b00) begin
            resp_c = 2'b10;
        end
`endif
    end

    assign acc_ok    = (resp_c == 2'b00);
    assign unused_ok = ^{axi.axi_arprot, axi.axi_awprot, addr_q[1:0]};

    always_comb begin
        state_d     = state_q;
        aw_lat_d    = aw_lat_q;
        w_lat_d     = w_lat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        bresp_d     = bresp_q;
        arready_c   = 1'b0;
        awready_c   = 1'b0;
        wready_c    = 1'b0;
        ar_hs       = 1'b0;
        ram_en_c    = 1'b0;
        ram_we_c    = 4'b0000;
        ram_addr_c  = '0;
        ram_wdata_c = '0;

        case (state_q)
            IDLE: begin
                arready_c = rstn && !aw_lat_q && !w_lat_q;
                ar_hs     = axi.axi_arvalid && arready_c;
                // A read handshake in this cycle blocks AW/W acceptance so the read wins cleanly.
                awready_c = rstn && !aw_lat_q && !ar_hs;
                wready_c  = rstn && !w_lat_q && !ar_hs;
                if (ar_hs) begin
                    addr_d  = axi.axi_araddr;
                    state_d = RD_ISSUE;
                end else begin
                    if (axi.axi_awvalid && awready_c) begin
                        aw_lat_d = 1'b1;
                        addr_d   = axi.axi_awaddr;
                    end
                    if (axi.axi_wvalid && wready_c) begin
                        w_lat_d = 1'b1;
                        wdata_d = axi.axi_wdata;
                        wstrb_d = axi.axi_wstrb;
                    end
                    if (aw_lat_d && w_lat_d) begin
                        state_d = WR_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                ram_en_c   = acc_ok;
                ram_addr_c = addr_q[ADDR_BITS-1:2];
                rresp_d    = resp_c;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d = acc_ok ? ram_rdata : 32'h0;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (axi.axi_rready) begin
                    state_d = IDLE;
                end
            end
            WR_ISSUE: begin
                ram_en_c    = acc_ok;
                ram_we_c    = acc_ok ? wstrb_q : 4'b0000;
                ram_addr_c  = addr_q[ADDR_BITS-1:2];
                ram_wdata_c = wdata_q;
                bresp_d     = resp_c;
                aw_lat_d    = 1'b0;
                w_lat_d     = 1'b0;
                state_d     = WR_RESP;
            end
            WR_RESP: begin
                if (axi.axi_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            aw_lat_q <= 1'b0;
            w_lat_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            bresp_q  <= '0;
        end else begin
            state_q  <= state_d;
            aw_lat_q <= aw_lat_d;
            w_lat_q  <= w_lat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
        end
    end

    // Reset is synchronous, so an issue state can still be live while rstn is low; gate the strobes.
    assign ram_en    = rstn && ram_en_c;
    assign ram_we    = rstn ? ram_we_c : 4'b0000;
    assign ram_addr  = ram_addr_c;
    assign ram_wdata = ram_wdata_c;

    assign axi.axi_arready = arready_c;
    assign axi.axi_awready = awready_c;
    assign axi.axi_wready  = wready_c;
    assign axi.axi_rvalid  = (state_q == RD_RESP);
    assign axi.axi_bvalid  = (state_q == WR_RESP);
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;
    assign axi.axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_ram_bridge.sv
// Directed bench for axi_ram_bridge with a behavioural BRAM and strobe monitor.
// Honours AXI_RAM_BRIDGE_ALIGN_CHECK_EN for the misaligned-read expectation.
module tb_axi_ram_bridge;
    localparam int AB = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_ram_bridge_if axi();
    logic [AB-3:0] ram_addr;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    axi_ram_bridge #(.ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .axi       (axi),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    logic [31:0] mem [0:(1<<(AB-2))-1];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    int          en_cnt = 0;
    int          we_cnt = 0;
    logic [3:0]  last_we = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    always @(negedge clk) begin
        if (ram_en) begin
            en_cnt++;
            last_we    = ram_we;
            last_addr  = 32'(ram_addr);
            last_wdata = ram_wdata;
            if (ram_we != 4'b0000) we_cnt++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        bit done;
        done = 1'b0;
        axi.axi_araddr  = addr;
        axi.axi_arvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            done = axi.axi_arready;
            tick();
        end
        axi.axi_arvalid = 1'b0;
        if (!done) chk("ar_timeout", 32'd0, 32'd1);
        lat = 1;
        while (!axi.axi_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        data = axi.axi_rdata;
        resp = axi.axi_rresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_rvalid", 32'(axi.axi_rvalid), 32'd1);
            chk("bp_rdata", axi.axi_rdata, data);
            chk("bp_arready", 32'(axi.axi_arready), 32'd0);
        end
        axi.axi_rready = 1'b1;
        tick();
        axi.axi_rready = 1'b0;
        chk("r_done", 32'(axi.axi_rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat);
        bit aw_done, w_done, a_hs, w_hs;
        aw_done = 1'b0;
        w_done  = 1'b0;
        axi.axi_awaddr = addr;
        axi.axi_wdata  = data;
        axi.axi_wstrb  = strb;
        for (int t = 0; t < 20 && !(aw_done && w_done); t++) begin
            axi.axi_awvalid = !aw_done && (t >= aw_dly);
            axi.axi_wvalid  = !w_done && (t >= w_dly);
            #1;
            a_hs = axi.axi_awvalid && axi.axi_awready;
            w_hs = axi.axi_wvalid && axi.axi_wready;
            tick();
            if (a_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
        end
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_timeout", 32'd0, 32'd1);
        lat = 1;
        while (!axi.axi_bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp = axi.axi_bresp;
        axi.axi_bready = 1'b1;
        tick();
        axi.axi_bready = 1'b0;
        chk("b_done", 32'(axi.axi_bvalid), 32'd0);
    endtask

    logic [31:0] rd_data;
    logic [1:0]  rsp;
    int          lat, e0, w0;

    initial begin
        axi.axi_araddr = '0; axi.axi_arvalid = 1'b0; axi.axi_arprot = '0; axi.axi_rready = 1'b0;
        axi.axi_awaddr = '0; axi.axi_awvalid = 1'b0; axi.axi_awprot = '0;
        axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wvalid = 1'b0; axi.axi_bready = 1'b0;

        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_arready", 32'(axi.axi_arready), 32'd0);
        chk("rst_rvalid", 32'(axi.axi_rvalid), 32'd0);
        chk("rst_bvalid", 32'(axi.axi_bvalid), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_rdata", axi.axi_rdata, 32'h0);
        chk("rst_resp", {28'd0, axi.axi_rresp, axi.axi_bresp}, 32'h0);
        rstn = 1'b1;
        #1;
        chk("idle_arready", 32'(axi.axi_arready), 32'd1);
        chk("idle_awready", 32'(axi.axi_awready), 32'd1);
        tick();

        // full-word write with AW and W together, then read back
        e0 = en_cnt;
        do_write(32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 0, rsp, lat);
        chk("w1_lat", 32'(lat), 32'd2);
        chk("w1_bresp", 32'(rsp), 32'd0);
        chk("w1_en", 32'(en_cnt - e0), 32'd1);
        chk("w1_we", 32'(last_we), 32'hF);
        chk("w1_addr", last_addr, 32'd4);
        chk("w1_wdata", last_wdata, 32'hDEADBEEF);
        e0 = en_cnt;
        do_read(32'h0000_0010, 0, rd_data, rsp, lat);
        chk("r1_lat", 32'(lat), 32'd3);
        chk("r1_data", rd_data, 32'hDEADBEEF);
        chk("r1_rresp", 32'(rsp), 32'd0);
        chk("r1_en", 32'(en_cnt - e0), 32'd1);

        // byte write, W two cycles ahead of AW
        e0 = en_cnt;
        do_write(32'h0000_0010, 32'h00AA0000, 4'b0100, 2, 0, rsp, lat);
        chk("w2_en", 32'(en_cnt - e0), 32'd1);
        chk("w2_we", 32'(last_we), 32'h4);
        chk("w2_bresp", 32'(rsp), 32'd0);
        chk("w2_lat", 32'(lat), 32'd2);
        do_read(32'h0000_0010, 0, rd_data, rsp, lat);
        chk("r2_data", rd_data, 32'hDEAABEEF);

        // out of range
        e0 = en_cnt;
        do_read(32'h0001_0000, 0, rd_data, rsp, lat);
        chk("oor_r_en", 32'(en_cnt - e0), 32'd0);
        chk("oor_rresp", 32'(rsp), 32'd3);
        chk("oor_rdata", rd_data, 32'h0);
        chk("oor_r_lat", 32'(lat), 32'd3);
        e0 = en_cnt;
        w0 = we_cnt;
        do_write(32'h0001_0000, 32'h55555555, 4'hF, 0, 0, rsp, lat);
        chk("oor_bresp", 32'(rsp), 32'd3);
        chk("oor_w_en", 32'(en_cnt - e0), 32'd0);
        chk("oor_w_we", 32'(we_cnt - w0), 32'd0);

        // zero strobe write
        e0 = en_cnt;
        w0 = we_cnt;
        do_write(32'h0000_0020, 32'hFFFFFFFF, 4'b0000, 0, 1, rsp, lat);
        chk("s0_bresp", 32'(rsp), 32'd0);
        chk("s0_we", 32'(we_cnt - w0), 32'd0);
        chk("s0_en", 32'(en_cnt - e0), 32'd1);

        // backpressure
        do_read(32'h0000_0010, 5, rd_data, rsp, lat);
        chk("bp_data", rd_data, 32'hDEAABEEF);

        // collision: AR and AW+W valid together, read first
        e0 = en_cnt;
        axi.axi_araddr = 32'h0000_0010; axi.axi_arvalid = 1'b1;
        axi.axi_awaddr = 32'h0000_0030; axi.axi_awvalid = 1'b1;
        axi.axi_wdata = 32'h12345678; axi.axi_wstrb = 4'hF; axi.axi_wvalid = 1'b1;
        #1;
        chk("col_arready", 32'(axi.axi_arready), 32'd1);
        chk("col_awready", 32'(axi.axi_awready), 32'd0);
        chk("col_wready", 32'(axi.axi_wready), 32'd0);
        tick();
        axi.axi_arvalid = 1'b0;
        lat = 1;
        while (!axi.axi_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk("col_r_lat", 32'(lat), 32'd3);
        chk("col_rdata", axi.axi_rdata, 32'hDEAABEEF);
        chk("col_no_wr", 32'(en_cnt - e0), 32'd1);
        chk("col_bvalid", 32'(axi.axi_bvalid), 32'd0);
        axi.axi_rready = 1'b1;
        tick();
        axi.axi_rready = 1'b0;
        chk("col_awready2", {30'd0, axi.axi_awready, axi.axi_wready}, 32'd3);
        tick();
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid = 1'b0;
        lat = 1;
        while (!axi.axi_bvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk("col_w_lat", 32'(lat), 32'd2);
        chk("col_bresp", 32'(axi.axi_bresp), 32'd0);
        axi.axi_bready = 1'b1;
        tick();
        axi.axi_bready = 1'b0;
        do_read(32'h0000_0030, 0, rd_data, rsp, lat);
        chk("col_readback", rd_data, 32'h12345678);

        // reset in RD_WAIT
        axi.axi_araddr = 32'h0000_0010;
        axi.axi_arvalid = 1'b1;
        #1;
        tick();
        axi.axi_arvalid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        chk("mrst_rvalid", 32'(axi.axi_rvalid), 32'd0);
        chk("mrst_arready", 32'(axi.axi_arready), 32'd0);
        chk("mrst_ram_en", 32'(ram_en), 32'd0);
        chk("mrst_rdata", axi.axi_rdata, 32'h0);
        rstn = 1'b1;
        tick();
        chk("mrst_idle_rvalid", 32'(axi.axi_rvalid), 32'd0);
        do_read(32'h0000_0010, 0, rd_data, rsp, lat);
        chk("mrst_r_data", rd_data, 32'hDEAABEEF);
        chk("mrst_r_resp", 32'(rsp), 32'd0);
        chk("mrst_r_lat", 32'(lat), 32'd3);

        // misaligned read
        e0 = en_cnt;
        do_read(32'h0000_0012, 0, rd_data, rsp, lat);
`ifdef AXI_RAM_BRIDGE_ALIGN_CHECK_EN
        chk("mis_rresp", 32'(rsp), 32'd2);
        chk("mis_rdata", rd_data, 32'h0);
        chk("mis_en", 32'(en_cnt - e0), 32'd0);
`else
        chk("mis_rresp", 32'(rsp), 32'd0);
        chk("mis_rdata", rd_data, 32'hDEAABEEF);
        chk("mis_en", 32'(en_cnt - e0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
